// File: rtl/case_demux_pkg.sv
// -----------------------------------------------------------------------------
// case_demux_pkg
// Shared definitions for the case_demux_router slice:
//   - select encodings (SEL_A/B/C route to a slot, SEL_BAD is the sink code)
//   - default widths for the data path and the saturating error counter
//   - slot index constants (bit positions in out_valid / out_ready)
//   - next_slot(): round-robin successor A -> B -> C -> A
// -----------------------------------------------------------------------------
package case_demux_pkg;

  localparam int DATA_W_DEF = 3;
  localparam int ERR_W_DEF  = 4;
  localparam int NUM_SLOTS  = 3;

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_C   = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  localparam int SLOT_A = 0;
  localparam int SLOT_B = 1;
  localparam int SLOT_C = 2;

  // Successor of a slot code; never yields SEL_BAD.
  function automatic logic [1:0] next_slot(input logic [1:0] cur);
    return (cur == SEL_C) ? SEL_A : cur + 2'd1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// Single-entry output buffer with a valid/ready handshake on its output side.
// The parent only asserts load_i when the slot is empty or draining this cycle,
// so a load always wins over a drain and gives full 1 beat/cycle throughput.
// Data is held stable while valid_o & ~ready_i.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous reset, active low (clears valid and data)
//   load_i   in   write data_i into the slot at the next edge
//   ready_i  in   consumer ready
//   data_i   in   payload to load
//   valid_o  out  slot holds a beat
//   data_o   out  slot payload
// -----------------------------------------------------------------------------
module demux_slot #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      // Drained with no reload: drop valid, keep the stale payload.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/case_demux_router.sv
// -----------------------------------------------------------------------------
// case_demux_router
// 3-way demultiplexer: one tagged input stream is steered into one of three
// single-entry output slots (A, B, C), each with its own valid/ready handshake.
// Select code 2'b11 is sunk without touching any slot and counted in a
// saturating error counter.
//
// Build option: CASE_DEMUX_ROUND_ROBIN_EN
//   defined   - in_sel is ignored; destination comes from an internal pointer
//               cycling A -> B -> C -> A, advancing on every accept.
//   undefined - in_sel steers; no pointer register exists.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   in_valid   in   producer beat valid
//   in_ready   out  router can accept a beat this cycle (independent of in_valid)
//   in_sel     in   destination: 00=A, 01=B, 10=C, 11=invalid
//   in_data    in   payload
//   out_valid  out  per-slot valid, bit0=A bit1=B bit2=C
//   out_ready  in   per-slot consumer ready
//   out_a/b/c  out  slot payloads
//   err_cnt    out  beats sunk via select 11, saturating
// -----------------------------------------------------------------------------
module case_demux_router
  import case_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ERR_W  = ERR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_SLOTS-1:0] out_valid,
  input  logic [NUM_SLOTS-1:0] out_ready,
  output logic [DATA_W-1:0]    out_a,
  output logic [DATA_W-1:0]    out_b,
  output logic [DATA_W-1:0]    out_c,
  output logic [ERR_W-1:0]     err_cnt
);

  logic [1:0]           dest;
  logic                 accept;
  logic [NUM_SLOTS-1:0] slot_load;
  logic [DATA_W-1:0]    slot_data [NUM_SLOTS];
  logic [ERR_W-1:0]     err_q, err_d;

`ifdef CASE_DEMUX_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic       unused_sel;

  assign unused_sel = ^in_sel;
  assign dest       = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = next_slot(ptr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SEL_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign dest = in_sel;
`endif

  // Ready is decided from the destination slot alone so it never looks at
  // in_valid; the sink code can always take a beat.
  always_comb begin
    in_ready = 1'b1;
    case (dest)
      SEL_A:   in_ready = ~out_valid[SLOT_A] | out_ready[SLOT_A];
      SEL_B:   in_ready = ~out_valid[SLOT_B] | out_ready[SLOT_B];
      SEL_C:   in_ready = ~out_valid[SLOT_C] | out_ready[SLOT_C];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign slot_load[gi] = accept & (dest == 2'(gi));

      demux_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (slot_load[gi]),
        .ready_i (out_ready[gi]),
        .data_i  (in_data),
        .valid_o (out_valid[gi]),
        .data_o  (slot_data[gi])
      );
    end
  endgenerate

  assign out_a = slot_data[SLOT_A];
  assign out_b = slot_data[SLOT_B];
  assign out_c = slot_data[SLOT_C];

  // Saturating count of sunk beats; holds at all-ones instead of wrapping.
  always_comb begin
    err_d = err_q;
    if (accept && (dest == SEL_BAD) && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;

endmodule

// File: tb/tb_case_demux_router.sv
module tb_case_demux_router;
  import case_demux_pkg::*;

  localparam int DW = 3;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_data;
  logic [2:0]    out_valid;
  logic [2:0]    out_ready;
  logic [DW-1:0] out_a, out_b, out_c;
  logic [EW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  case_demux_router #(.DATA_W(DW), .ERR_W(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic          v;
    logic [1:0]    sel;
    logic [DW-1:0] d;
    logic [2:0]    rdy;
    logic          exp_ir;
    logic [2:0]    exp_ov;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [DW-1:0] exp_c;
    logic [EW-1:0] exp_err;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;

  task automatic add(input logic v, input logic [1:0] sel, input int d,
                     input logic [2:0] rdy, input logic ir, input logic [2:0] ov,
                     input int a, input int b, input int c, input int e);
    vecs[nvec].v       = v;
    vecs[nvec].sel     = sel;
    vecs[nvec].d       = DW'(d);
    vecs[nvec].rdy     = rdy;
    vecs[nvec].exp_ir  = ir;
    vecs[nvec].exp_ov  = ov;
    vecs[nvec].exp_a   = DW'(a);
    vecs[nvec].exp_b   = DW'(b);
    vecs[nvec].exp_c   = DW'(c);
    vecs[nvec].exp_err = EW'(e);
    nvec++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    // Reset held with a valid beat presented: nothing may load.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = SEL_A;
    in_data   = 3'd3;
    out_ready = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_a", int'(out_a), 0);
    chk("rst_out_b", int'(out_b), 0);
    chk("rst_out_c", int'(out_c), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    $display("reset held: out_valid=%b out_a=%0d err_cnt=%0d", out_valid, out_a, err_cnt);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_accept_valid", int'(out_valid), 1);
    chk("first_accept_a", int'(out_a), 3);
    $display("release: out_valid=%b out_a=%0d", out_valid, out_a);

`ifndef CASE_DEMUX_ROUND_ROBIN_EN
    // Steering, one cycle latency each
    add(1, SEL_A, 5, 3'b111, 1, 3'b001, 5, 0, 0, 0);
    add(1, SEL_B, 6, 3'b111, 1, 3'b010, 0, 6, 0, 0);
    add(1, SEL_C, 7, 3'b111, 1, 3'b100, 0, 0, 7, 0);
    add(0, SEL_A, 0, 3'b111, 1, 3'b000, 0, 0, 0, 0);
    // Backpressure on B
    add(1, SEL_B, 1, 3'b101, 1, 3'b010, 0, 1, 0, 0);
    add(1, SEL_B, 2, 3'b101, 0, 3'b010, 0, 1, 0, 0);
    add(1, SEL_B, 2, 3'b101, 0, 3'b010, 0, 1, 0, 0);
    add(1, SEL_B, 2, 3'b111, 1, 3'b010, 0, 2, 0, 0);
    add(0, SEL_B, 0, 3'b111, 1, 3'b000, 0, 0, 0, 0);
    // Independent slots: stall on one, drain/load on another
    add(1, SEL_A, 4, 3'b000, 1, 3'b001, 4, 0, 0, 0);
    add(1, SEL_C, 6, 3'b000, 1, 3'b101, 4, 0, 6, 0);
    add(1, SEL_A, 1, 3'b000, 0, 3'b101, 4, 0, 6, 0);
    add(1, SEL_C, 2, 3'b001, 0, 3'b100, 0, 0, 6, 0);
    add(1, SEL_A, 1, 3'b100, 1, 3'b001, 1, 0, 0, 0);
    add(0, SEL_A, 0, 3'b111, 1, 3'b000, 0, 0, 0, 0);
    // Back-to-back stream into A
    for (int i = 0; i < 8; i++)
      add(1, SEL_A, i, 3'b111, 1, 3'b001, i, 0, 0, 0);
    add(0, SEL_A, 0, 3'b111, 1, 3'b000, 0, 0, 0, 0);
    // Default branch with A full and stalled
    add(1, SEL_A, 2, 3'b000, 1, 3'b001, 2, 0, 0, 0);
    add(0, SEL_A, 0, 3'b000, 0, 3'b001, 2, 0, 0, 0);
    add(0, SEL_BAD, 0, 3'b000, 1, 3'b001, 2, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      add(1, SEL_BAD, i, 3'b000, 1, 3'b001, 2, 0, 0, (i + 1 > 15) ? 15 : i + 1);
`else
    // Pointer is at B after the accept into A above
    add(1, SEL_BAD, 1, 3'b111, 1, 3'b010, 0, 1, 0, 0);
    add(1, SEL_BAD, 2, 3'b111, 1, 3'b100, 0, 0, 2, 0);
    add(1, SEL_BAD, 3, 3'b111, 1, 3'b001, 3, 0, 0, 0);
    add(1, SEL_BAD, 4, 3'b111, 1, 3'b010, 0, 4, 0, 0);
    add(1, SEL_BAD, 5, 3'b111, 1, 3'b100, 0, 0, 5, 0);
    add(1, SEL_BAD, 6, 3'b111, 1, 3'b001, 6, 0, 0, 0);
    add(1, SEL_BAD, 7, 3'b000, 1, 3'b011, 6, 7, 0, 0);
    add(1, SEL_BAD, 0, 3'b000, 1, 3'b111, 6, 7, 0, 0);
    add(1, SEL_BAD, 1, 3'b000, 0, 3'b111, 6, 7, 0, 0);
    add(1, SEL_BAD, 1, 3'b110, 0, 3'b001, 6, 0, 0, 0);
    add(1, SEL_BAD, 1, 3'b001, 1, 3'b001, 1, 0, 0, 0);
    add(0, SEL_BAD, 0, 3'b111, 1, 3'b000, 0, 0, 0, 0);
`endif

    for (int i = 0; i < nvec; i++) begin
      in_valid  = vecs[i].v;
      in_sel    = vecs[i].sel;
      in_data   = vecs[i].d;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].exp_ov));
      if (vecs[i].exp_ov[0]) chk($sformatf("v%0d_out_a", i), int'(out_a), int'(vecs[i].exp_a));
      if (vecs[i].exp_ov[1]) chk($sformatf("v%0d_out_b", i), int'(out_b), int'(vecs[i].exp_b));
      if (vecs[i].exp_ov[2]) chk($sformatf("v%0d_out_c", i), int'(out_c), int'(vecs[i].exp_c));
      chk($sformatf("v%0d_err_cnt", i), int'(err_cnt), int'(vecs[i].exp_err));
      $display("vec %0d: v=%b sel=%b d=%0d rdy=%b -> ir=%b ov=%b a=%0d b=%0d c=%0d err=%0d",
               i, vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].rdy, in_ready,
               out_valid, out_a, out_b, out_c, err_cnt);
    end

    // Asynchronous reset mid-cycle: outputs clear with no clock edge.
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_a", int'(out_a), 0);
    chk("async_rst_err", int'(err_cnt), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle_valid", int'(out_valid), 0);
    chk("post_rst_idle_err", int'(err_cnt), 0);
    $display("async reset: out_valid=%b err_cnt=%0d", out_valid, err_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
